mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 28 ++
 rtl/mem_bus_decode.sv | 36 +++
 rtl/mem_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the registered CPU memory/IO bus controller.
// Holds the FSM state enum, region codes, RAM lane enables and the read-lane steering helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAM  = 2'd1,
        S_IO   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] RGN_RAM  = 2'd0;
    localparam logic [1:0] RGN_BIOS = 2'd1;
    localparam logic [1:0] RGN_IO   = 2'd2;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    // Big-endian: an odd byte address lives in the low lane.
    function automatic logic [15:0] steer_rd(input logic [15:0] d, input logic byte_acc,
                                             input logic odd);
        if (!byte_acc)
            return d;
        return odd ? {8'h00, d[7:0]} : {8'h00, d[15:8]};
    endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational region / IO device-index decoder for one CPU byte address.
// Zero latency; no flow control.
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int BIOS_TOP = 'h0800,
    parameter int IO_BASE  = 'hff80,
    parameter int IO_DEVS  = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              bios_ena,
    input  logic              is_read,
    output logic [1:0]        region,
    output logic [2:0]        dev
);

    localparam logic [31:0] IO_END = 32'(IO_BASE + 16 * IO_DEVS);

    logic [31:0] a32;
    logic [6:0]  off;

    assign a32 = 32'(addr);
    // At most 8 devices of 16 bytes, so the low 7 bits of the offset suffice.
    assign off = a32[6:0] - 7'(IO_BASE);
    assign dev = 3'(off >> 4);

    always_comb begin
        region = RGN_RAM;
        if (is_read && bios_ena && a32 < 32'(BIOS_TOP))
            region = RGN_BIOS;
        else if (a32 >= 32'(IO_BASE) && a32 < IO_END)
            region = RGN_IO;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Registered CPU bus controller steering accesses to BIOS, RAM (with wait states) or IO devices.
// Latency: BIOS 1, RAM RAM_WAIT+2, IO ack+1 cycles; one access at a time, new strobes only taken in IDLE.
// Optional IO bus-error timeout under MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int BIOS_TOP = 'h0800,
    parameter int IO_BASE  = 'hff80,
    parameter int IO_DEVS  = 4,
    parameter int RAM_WAIT = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_CPU_addr,
    input  logic [15:0]           i_CPU_write,
    input  logic                  i_CPU_be,
    input  logic                  i_CPU_re,
    input  logic                  i_CPU_we,
    output logic [15:0]           o_CPU_read,
    output logic                  o_CPU_ack,
    output logic                  o_CPU_err,
    input  logic                  i_BIOS_ena,
    input  logic [15:0]           i_BIOS_read,
    output logic [ADDR_W-2:0]     o_RAM_addr,
    output logic [15:0]           o_RAM_write,
    output logic [1:0]            o_RAM_be,
    output logic                  o_RAM_we,
    output logic                  o_RAM_re,
    input  logic [15:0]           i_RAM_read,
    output logic [IO_DEVS-1:0]    o_IO_sel,
    output logic [3:0]            o_IO_addr,
    output logic [15:0]           o_IO_write,
    output logic                  o_IO_be,
    output logic                  o_IO_we,
    output logic                  o_IO_re,
    input  logic [16*IO_DEVS-1:0] i_IO_read,
    input  logic [IO_DEVS-1:0]    i_IO_ack
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wdat_q, rdat_q, io_rdat;
    logic                be_q, wr_q;
    logic [2:0]          dev_q, dev_d, wcnt;
    logic [1:0]          rgn;
    logic                req, io_hit, ram_act, io_act;
    logic [IO_DEVS-1:0]  sel_vec;

    assign req     = i_CPU_re | i_CPU_we;
    assign sel_vec = IO_DEVS'(1) << dev_q;
    assign io_hit  = |(i_IO_ack & sel_vec);

    mem_bus_decode #(
        .ADDR_W  (ADDR_W),
        .BIOS_TOP(BIOS_TOP),
        .IO_BASE (IO_BASE),
        .IO_DEVS (IO_DEVS)
    ) u_decode (
        .addr    (i_CPU_addr),
        .bios_ena(i_BIOS_ena),
        .is_read (~i_CPU_we),
        .region  (rgn),
        .dev     (dev_d)
    );

    always_comb begin
        io_rdat = '0;
        for (int i = 0; i < IO_DEVS; i++)
            if (3'(i) == dev_q)
                io_rdat = i_IO_read[16*i +: 16];
    end

`ifdef MEM_BUS_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err_q, tmo;
    assign tmo       = (tcnt == 8'(TIMEOUT - 1));
    assign o_CPU_err = err_q & (state == S_DONE);
`else
    logic tmo;
    assign tmo       = 1'b0;
    assign o_CPU_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req) begin
                case (rgn)
                    RGN_BIOS: state_nxt = S_DONE;
                    RGN_IO:   state_nxt = S_IO;
                    default:  state_nxt = S_RAM;
                endcase
            end
            S_RAM:  if (wcnt == 3'd0) state_nxt = S_DONE;
            S_IO:   if (io_hit || tmo) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
            be_q   <= 1'b0;
            wr_q   <= 1'b0;
            dev_q  <= '0;
            wcnt   <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            tcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    addr_q <= i_CPU_addr;
                    wdat_q <= i_CPU_write;
                    be_q   <= i_CPU_be;
                    wr_q   <= i_CPU_we;
                    dev_q  <= dev_d;
                    wcnt   <= 3'(RAM_WAIT);
`ifdef MEM_BUS_TIMEOUT_EN
                    tcnt   <= '0;
                    err_q  <= 1'b0;
`endif
                    // BIOS is an address-only ROM, so its data is valid at the request edge.
                    if (rgn == RGN_BIOS)
                        rdat_q <= steer_rd(i_BIOS_read, i_CPU_be, i_CPU_addr[0]);
                end
                S_RAM: begin
                    if (wcnt == 3'd0)
                        rdat_q <= steer_rd(i_RAM_read, be_q, addr_q[0]);
                    else
                        wcnt <= wcnt - 3'd1;
                end
                S_IO: begin
                    if (io_hit)
                        rdat_q <= io_rdat;
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (tmo) begin
                        rdat_q <= 16'hffff;
                        err_q  <= 1'b1;
                    end else
                        tcnt <= tcnt + 8'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign ram_act = (state == S_RAM);
    assign io_act  = (state == S_IO);

    assign o_CPU_read  = rdat_q;
    assign o_CPU_ack   = (state == S_DONE);

    assign o_RAM_addr  = addr_q[ADDR_W-1:1];
    assign o_RAM_write = be_q ? {2{wdat_q[7:0]}} : wdat_q;
    assign o_RAM_be    = !ram_act ? 2'b00 : (!be_q ? BE_WORD : (addr_q[0] ? BE_LO : BE_HI));
    assign o_RAM_we    = ram_act & wr_q;
    assign o_RAM_re    = ram_act & ~wr_q;

    assign o_IO_sel    = io_act ? sel_vec : '0;
    assign o_IO_addr   = addr_q[3:0];
    assign o_IO_write  = wdat_q;
    assign o_IO_be     = be_q;
    assign o_IO_we     = io_act & wr_q;
    assign o_IO_re     = io_act & ~wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl (RAM_WAIT=1, IO_DEVS=4, TIMEOUT=15).
module tb_mem_bus_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [18:0] i_CPU_addr = '0;
    logic [15:0] i_CPU_write = '0;
    logic        i_CPU_be = 1'b0;
    logic        i_CPU_re = 1'b0;
    logic        i_CPU_we = 1'b0;
    logic [15:0] o_CPU_read;
    logic        o_CPU_ack;
    logic        o_CPU_err;
    logic        i_BIOS_ena = 1'b0;
    logic [15:0] i_BIOS_read = '0;
    logic [17:0] o_RAM_addr;
    logic [15:0] o_RAM_write;
    logic [1:0]  o_RAM_be;
    logic        o_RAM_we;
    logic        o_RAM_re;
    logic [15:0] i_RAM_read = '0;
    logic [3:0]  o_IO_sel;
    logic [3:0]  o_IO_addr;
    logic [15:0] o_IO_write;
    logic        o_IO_be;
    logic        o_IO_we;
    logic        o_IO_re;
    logic [63:0] i_IO_read = {16'h4444, 16'h3333, 16'hC0DE, 16'h1111};
    logic [3:0]  i_IO_ack = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int acks;

    always #5 i_clk = ~i_clk;

    mem_bus_ctrl #(
        .ADDR_W(19), .BIOS_TOP('h0800), .IO_BASE('hff80),
        .IO_DEVS(4), .RAM_WAIT(1), .TIMEOUT(15)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_CPU_addr(i_CPU_addr), .i_CPU_write(i_CPU_write), .i_CPU_be(i_CPU_be),
        .i_CPU_re(i_CPU_re), .i_CPU_we(i_CPU_we),
        .o_CPU_read(o_CPU_read), .o_CPU_ack(o_CPU_ack), .o_CPU_err(o_CPU_err),
        .i_BIOS_ena(i_BIOS_ena), .i_BIOS_read(i_BIOS_read),
        .o_RAM_addr(o_RAM_addr), .o_RAM_write(o_RAM_write), .o_RAM_be(o_RAM_be),
        .o_RAM_we(o_RAM_we), .o_RAM_re(o_RAM_re), .i_RAM_read(i_RAM_read),
        .o_IO_sel(o_IO_sel), .o_IO_addr(o_IO_addr), .o_IO_write(o_IO_write),
        .o_IO_be(o_IO_be), .o_IO_we(o_IO_we), .o_IO_re(o_IO_re),
        .i_IO_read(i_IO_read), .i_IO_ack(i_IO_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request for exactly one sampling edge, then drop the strobes.
    task automatic issue(input logic [18:0] a, input logic re, input logic we,
                         input logic be, input logic [15:0] wd);
        i_CPU_addr  = a;
        i_CPU_re    = re;
        i_CPU_we    = we;
        i_CPU_be    = be;
        i_CPU_write = wd;
        tick();
        i_CPU_re = 1'b0;
        i_CPU_we = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ack",     32'(o_CPU_ack), 0);
        chk("rst_read",    32'(o_CPU_read), 0);
        chk("rst_ram_be",  32'(o_RAM_be), 0);
        chk("rst_ram_re",  32'(o_RAM_re), 0);
        chk("rst_io_sel",  32'(o_IO_sel), 0);
        chk("rst_err",     32'(o_CPU_err), 0);
        i_rst = 1'b0;
        tick();

        // RAM word read, one wait state: strobe two cycles, ack after the second.
        i_RAM_read = 16'hA55A;
        issue(19'h0100, 1, 0, 0, 16'h0000);
        chk("rd_re_c1",    32'(o_RAM_re), 1);
        chk("rd_addr",     32'(o_RAM_addr), 32'h080);
        chk("rd_be",       32'(o_RAM_be), 32'h3);
        chk("rd_noack_c1", 32'(o_CPU_ack), 0);
        tick();
        chk("rd_re_c2",    32'(o_RAM_re), 1);
        chk("rd_noack_c2", 32'(o_CPU_ack), 0);
        tick();
        chk("rd_ack",      32'(o_CPU_ack), 1);
        chk("rd_re_off",   32'(o_RAM_re), 0);
        chk("rd_data",     32'(o_CPU_read), 32'hA55A);
        tick();
        chk("rd_ack_off",  32'(o_CPU_ack), 0);
        chk("rd_hold",     32'(o_CPU_read), 32'hA55A);

        // Byte write to an odd address: low lane enabled, byte replicated.
        issue(19'h0101, 0, 1, 1, 16'hAB3C);
        chk("bw_wdat",     32'(o_RAM_write), 32'h3C3C);
        chk("bw_be",       32'(o_RAM_be), 32'h1);
        chk("bw_we_c1",    32'(o_RAM_we), 1);
        chk("bw_re",       32'(o_RAM_re), 0);
        tick();
        chk("bw_we_c2",    32'(o_RAM_we), 1);
        tick();
        chk("bw_ack",      32'(o_CPU_ack), 1);
        chk("bw_we_off",   32'(o_RAM_we), 0);
        tick();

        // Byte read from even address takes the high lane.
        i_RAM_read = 16'h1234;
        issue(19'h0100, 1, 0, 1, 16'h0000);
        chk("br_be",       32'(o_RAM_be), 32'h2);
        tick();
        tick();
        chk("br_ack",      32'(o_CPU_ack), 1);
        chk("br_data",     32'(o_CPU_read), 32'h0012);
        tick();

        // BIOS overlay read: ack immediately, RAM untouched.
        i_BIOS_ena  = 1'b1;
        i_BIOS_read = 16'hBEEF;
        issue(19'h07FE, 1, 0, 0, 16'h0000);
        chk("bios_ack",    32'(o_CPU_ack), 1);
        chk("bios_data",   32'(o_CPU_read), 32'hBEEF);
        chk("bios_no_ram", 32'(o_RAM_re), 0);
        tick();
        chk("bios_ack_off", 32'(o_CPU_ack), 0);

        // BIOS byte read at odd address picks the low lane.
        issue(19'h07FF, 1, 0, 1, 16'h0000);
        chk("bios_b_data", 32'(o_CPU_read), 32'h00EF);
        tick();

        // BIOS write falls through to RAM.
        issue(19'h07FE, 0, 1, 0, 16'h7777);
        chk("bios_wr_ram", 32'(o_RAM_we), 1);
        tick();
        tick();
        tick();

        // Overlay off: same address goes to RAM.
        i_BIOS_ena = 1'b0;
        i_RAM_read = 16'h1111;
        issue(19'h07FE, 1, 0, 0, 16'h0000);
        chk("nobios_re",   32'(o_RAM_re), 1);
        chk("nobios_addr", 32'(o_RAM_addr), 32'h3FF);
        chk("nobios_noack", 32'(o_CPU_ack), 0);
        tick();
        tick();
        chk("nobios_ack",  32'(o_CPU_ack), 1);
        chk("nobios_data", 32'(o_CPU_read), 32'h1111);
        tick();

        // IO read from device 1 offset 5, with a spurious ack from device 0.
        issue(19'hFF95, 1, 0, 1, 16'h0000);
        chk("io_sel",      32'(o_IO_sel), 32'h2);
        chk("io_addr",     32'(o_IO_addr), 32'h5);
        chk("io_re",       32'(o_IO_re), 1);
        chk("io_be",       32'(o_IO_be), 1);
        i_IO_ack = 4'b0001;
        tick();
        i_IO_ack = 4'b0000;
        chk("io_spur_noack", 32'(o_CPU_ack), 0);
        chk("io_spur_sel", 32'(o_IO_sel), 32'h2);
        tick();
        i_IO_ack = 4'b0010;
        tick();
        i_IO_ack = 4'b0000;
        chk("io_ack",      32'(o_CPU_ack), 1);
        chk("io_data",     32'(o_CPU_read), 32'hC0DE);
        chk("io_sel_off",  32'(o_IO_sel), 0);
        chk("io_err",      32'(o_CPU_err), 0);
        tick();

        // Both strobes: treated as a word write.
        issue(19'h0200, 1, 1, 0, 16'h5A5A);
        chk("both_we",     32'(o_RAM_we), 1);
        chk("both_re",     32'(o_RAM_re), 0);
        chk("both_wdat",   32'(o_RAM_write), 32'h5A5A);
        tick();
        tick();
        chk("both_ack",    32'(o_CPU_ack), 1);
        tick();

`ifdef MEM_BUS_TIMEOUT_EN
        // Unanswered IO write to device 3 times out after 15 IO cycles.
        issue(19'hFFB0, 0, 1, 0, 16'h9999);
        chk("tmo_sel",     32'(o_IO_sel), 32'h8);
        chk("tmo_we",      32'(o_IO_we), 1);
        acks = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            acks += int'(o_CPU_ack);
        end
        chk("tmo_early_ack", 32'(acks), 0);
        tick();
        chk("tmo_ack",     32'(o_CPU_ack), 1);
        chk("tmo_err",     32'(o_CPU_err), 1);
        chk("tmo_data",    32'(o_CPU_read), 32'hFFFF);
        tick();
        chk("tmo_idle_ack", 32'(o_CPU_ack), 0);
        chk("tmo_idle_err", 32'(o_CPU_err), 0);
        chk("tmo_idle_sel", 32'(o_IO_sel), 0);
`else
        // Without the timeout the IO access waits as long as needed.
        issue(19'hFFB0, 0, 1, 0, 16'h9999);
        chk("wait_sel",    32'(o_IO_sel), 32'h8);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acks += int'(o_CPU_ack);
        end
        chk("wait_noack",  32'(acks), 0);
        chk("wait_sel2",   32'(o_IO_sel), 32'h8);
        i_IO_ack = 4'b1000;
        tick();
        i_IO_ack = 4'b0000;
        chk("wait_ack",    32'(o_CPU_ack), 1);
        chk("wait_err",    32'(o_CPU_err), 0);
        chk("wait_data",   32'(o_CPU_read), 32'h4444);
        tick();
`endif

        // Reset in the middle of a RAM wait: everything drops at once, no ack afterwards.
        i_RAM_read = 16'h2222;
        issue(19'h0300, 1, 0, 0, 16'h0000);
        chk("mid_re",      32'(o_RAM_re), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_re",   32'(o_RAM_re), 0);
        chk("mid_rst_be",   32'(o_RAM_be), 0);
        chk("mid_rst_addr", 32'(o_RAM_addr), 0);
        chk("mid_rst_read", 32'(o_CPU_read), 0);
        tick();
        i_rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(o_CPU_ack);
        end
        chk("mid_rst_noack", 32'(acks), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
